// File: rtl/delay_ram_scheduler.sv
// Shares one single-port delay-line SRAM among NREQ effects: per frame, one write then one
// delayed read for each enabled requester, each inside its own 2^REGION_W-word ring.
module delay_ram_scheduler #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int REGION_W = 13,
  parameter int RD_LAT   = 2
) (
  input  logic                       clk,
  input  logic                       ADCLRCK,
  input  logic                       frame_start,
  input  logic [NREQ-1:0]            en,
  input  logic [NREQ*DATA_W-1:0]     wr_data,
  input  logic [NREQ*REGION_W-1:0]   rd_delay,
  input  logic                       overrun_clr,
  output logic [NREQ*DATA_W-1:0]     rd_data,
  output logic [NREQ-1:0]            rd_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_d,
  output logic                       ram_we,
  input  logic [DATA_W-1:0]          ram_q
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

  // The scan step is resolved combinationally on the IDLE/WAIT exit edge, so it costs no cycle.
  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [ADDR_W-1:0]     ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0]     ram_d_reg, ram_d_next;
  logic                  overrun_reg, overrun_next;

  logic [DATA_W-1:0]     wr_data_arr [NREQ];
  logic [DATA_W-1:0]     wr_sh_arr   [NREQ];
  logic [REGION_W-1:0]   dly_sh_arr  [NREQ];
  logic [REGION_W-1:0]   wp_arr      [NREQ];
  logic [NREQ-1:0]       en_sh;

  logic                  accept;
  logic                  wait_last;
  logic                  first_hit, next_hit;
  logic [IDX_W-1:0]      first_idx, next_idx;
  logic [REGION_W-1:0]   rd_ptr;

  assign accept    = (state_reg == IDLE) && frame_start;
  assign wait_last = (state_reg == WAIT) && (wait_cnt_reg == WAIT_LAST);
  assign rd_ptr    = wp_arr[idx_reg] - dly_sh_arr[idx_reg];

  // Lowest enabled index: from the live enables at frame start, above idx_reg afterwards.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (en[k]) begin
        first_hit = 1'b1;
        first_idx = IDX_W'(k);
      end
      if (en_sh[k] && (k > int'(idx_reg))) begin
        next_hit = 1'b1;
        next_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    wait_cnt_next = wait_cnt_reg;
    ram_addr_next = ram_addr_reg;
    ram_d_next    = ram_d_reg;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          idx_next = '0;
          if (first_hit) begin
            state_next    = WRITE;
            idx_next      = first_idx;
            ram_addr_next = ADDR_W'({first_idx, wp_arr[first_idx]});
            ram_d_next    = wr_data_arr[first_idx];
          end
        end
      end
      WRITE: begin
        state_next    = READ;
        ram_addr_next = ADDR_W'({idx_reg, rd_ptr});
      end
      READ: begin
        state_next    = WAIT;
        wait_cnt_next = '0;
      end
      WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          if (next_hit) begin
            state_next    = WRITE;
            idx_next      = next_idx;
            ram_addr_next = ADDR_W'({next_idx, wp_arr[next_idx]});
            ram_d_next    = wr_sh_arr[next_idx];
          end else begin
            state_next = IDLE;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new overrun event outranks a simultaneous clear.
  always_comb begin
    overrun_next = overrun_reg;
    if (frame_start && busy)
      overrun_next = 1'b1;
    else if (overrun_clr)
      overrun_next = 1'b0;
  end

  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      ram_addr_reg <= '0;
      ram_d_reg    <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      wait_cnt_reg <= wait_cnt_next;
      ram_addr_reg <= ram_addr_next;
      ram_d_reg    <= ram_d_next;
      overrun_reg  <= overrun_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [REGION_W-1:0] wp_reg;
      logic [REGION_W-1:0] dly_sh_reg;
      logic [DATA_W-1:0]   wr_sh_reg;
      logic [DATA_W-1:0]   rd_data_reg;
      logic                en_sh_reg;
      logic                rd_valid_reg;
      logic                sel;

      assign sel = (idx_reg == IDX_W'(gi));

      always_ff @(posedge clk or posedge ADCLRCK) begin
        if (ADCLRCK) begin
          wp_reg       <= '0;
          dly_sh_reg   <= '0;
          wr_sh_reg    <= '0;
          rd_data_reg  <= '0;
          en_sh_reg    <= 1'b0;
          rd_valid_reg <= 1'b0;
        end else begin
          if (accept) begin
            en_sh_reg  <= en[gi];
            wr_sh_reg  <= wr_data[gi*DATA_W +: DATA_W];
            dly_sh_reg <= rd_delay[gi*REGION_W +: REGION_W];
          end
          // Read address used the pre-increment pointer, so delay 0 returns this frame's sample.
          if ((state_reg == READ) && sel)
            wp_reg <= wp_reg + 1'b1;
          rd_valid_reg <= wait_last && sel;
          if (wait_last && sel)
            rd_data_reg <= ram_q;
        end
      end

      assign wr_data_arr[gi]                = wr_data[gi*DATA_W +: DATA_W];
      assign wr_sh_arr[gi]                  = wr_sh_reg;
      assign dly_sh_arr[gi]                 = dly_sh_reg;
      assign wp_arr[gi]                     = wp_reg;
      assign en_sh[gi]                      = en_sh_reg;
      assign rd_data[gi*DATA_W +: DATA_W]   = rd_data_reg;
      assign rd_valid[gi]                   = rd_valid_reg;
    end
  endgenerate

  assign busy     = (state_reg != IDLE);
  assign ram_we   = (state_reg == WRITE);
  assign ram_addr = ram_addr_reg;
  assign ram_d    = ram_d_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_delay_ram_scheduler.sv
// Directed bench for delay_ram_scheduler: table of frames against a behavioural SRAM with
// RD_LAT read latency, plus hand sequences for wrap-around, overrun and mid-schedule reset.
module tb_delay_ram_scheduler;
  localparam int NREQ = 3, ADDR_W = 16, DATA_W = 16, REGION_W = 13, RD_LAT = 2;

  logic                     clk = 1'b0;
  logic                     ADCLRCK = 1'b0;
  logic                     frame_start = 1'b0;
  logic [NREQ-1:0]          en = '0;
  logic [NREQ*DATA_W-1:0]   wr_data = '0;
  logic [NREQ*REGION_W-1:0] rd_delay = '0;
  logic                     overrun_clr = 1'b0;
  logic [NREQ*DATA_W-1:0]   rd_data;
  logic [NREQ-1:0]          rd_valid;
  logic                     busy, overrun, ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_d, ram_q;

  always #5 clk = ~clk;

  delay_ram_scheduler #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .REGION_W(REGION_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .ADCLRCK(ADCLRCK), .frame_start(frame_start), .en(en),
    .wr_data(wr_data), .rd_delay(rd_delay), .overrun_clr(overrun_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .overrun(overrun),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Behavioural SRAM: write on the edge, read data emerges RD_LAT cycles after the address.
  bit [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  bit [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_q = pipe[RD_LAT-1];

  typedef struct packed {
    logic             rst;
    logic [2:0]       en;
    logic [2:0][15:0] wd;
    logic [2:0][12:0] dly;
    logic [2:0][15:0] wa;
    logic [2:0][15:0] ra;
    logic [2:0][15:0] q;
    logic [7:0]       busy;
    logic [7:0]       glitch;
    logic             glitch_clr;
    logic             ovr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd [3];
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [2:0] e, input logic [7:0] b);
    vec_t v;
    v = '0;
    v.rst = rst;
    v.en = e;
    v.busy = b;
    return v;
  endfunction

  function automatic vec_t req(input vec_t v_in, input int j, input logic [15:0] wd,
                               input logic [12:0] dly, input logic [15:0] wa,
                               input logic [15:0] ra, input logic [15:0] q);
    vec_t v;
    v = v_in;
    v.wd[j] = wd;
    v.dly[j] = dly;
    v.wa[j] = wa;
    v.ra[j] = ra;
    v.q[j] = q;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    ADCLRCK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ADCLRCK = 1'b0;
    for (int j = 0; j < 3; j++) exp_rd[j] = '0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [15:0] wa [3];
    logic [15:0] ra [3];
    logic [15:0] wd [3];
    int vcnt [3];
    int vcyc [3];
    int nw, bcnt, slot;
    bit pend, done;
    nw = 0; bcnt = 0; slot = 0; pend = 0; done = 0;
    for (int j = 0; j < 3; j++) begin
      vcnt[j] = 0; vcyc[j] = 0; wa[j] = 'x; ra[j] = 'x; wd[j] = 'x;
    end
    if (v.rst) do_reset();
    @(negedge clk);
    en = v.en;
    wr_data = v.wd;
    rd_delay = v.dly;
    frame_start = 1'b1;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (ram_we) begin
        if (nw < 3) begin wa[nw] = ram_addr; wd[nw] = ram_d; end
        pend = 1;
      end else if (pend) begin
        if (nw < 3) ra[nw] = ram_addr;
        nw++;
        pend = 0;
      end
      for (int r = 0; r < 3; r++)
        if (rd_valid[r]) begin vcnt[r]++; vcyc[r] = c; end
      frame_start = (c == int'(v.glitch));
      overrun_clr = frame_start && v.glitch_clr;
      if (frame_start) begin
        en = '1; wr_data = {3{16'h9999}}; rd_delay = '1;
      end
      if (!busy && !frame_start) done = 1;
    end
    frame_start = 1'b0;
    overrun_clr = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: busy still %0b after 60 cycles, required 0", tag, busy);
    end
    chk({tag, " busy_cycles"}, bcnt, v.busy);
    for (int j = 0; j < 3; j++) begin
      if (v.en[j]) begin
        chk($sformatf("%s wr_addr%0d", tag, j), wa[slot], v.wa[j]);
        chk($sformatf("%s wr_data%0d", tag, j), wd[slot], v.wd[j]);
        chk($sformatf("%s rd_addr%0d", tag, j), ra[slot], v.ra[j]);
        chk($sformatf("%s valid_cycle%0d", tag, j), vcyc[j], (slot + 1) * (2 + RD_LAT) + 1);
        exp_rd[j] = v.q[j];
        slot++;
      end
    end
    chk({tag, " writes"}, nw, slot);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s valid_count%0d", tag, j), vcnt[j], {31'd0, v.en[j]});
      chk($sformatf("%s rd_data%0d", tag, j), rd_data[j*16 +: 16], exp_rd[j]);
    end
    chk({tag, " overrun"}, overrun, v.ovr);
    $display("frame %s en=%b busy=%0d writes=%0d rd_data=%h overrun=%0b",
             tag, v.en, bcnt, nw, rd_data, overrun);
  endtask

  initial begin
    vec_t v;
    int vseen;

    tbl[0] = req(mk(1'b0, 3'b001, 8'd4), 0, 16'h1234, 13'd0, 16'h0000, 16'h0000, 16'h1234);
    for (int k = 1; k <= 10; k++)
      tbl[k] = req(mk(k == 1, 3'b001, 8'd4), 0, 16'(k), 13'd3, 16'(k - 1),
                   16'((k - 4) & 'h1FFF), (k > 3) ? 16'(k - 3) : 16'h0000);
    tbl[11] = req(req(mk(1'b0, 3'b101, 8'd8), 0, 16'hAAAA, 13'd0, 16'h000A, 16'h000A, 16'hAAAA),
                  2, 16'hBBBB, 13'd0, 16'h4000, 16'h4000, 16'hBBBB);
    tbl[12] = req(req(mk(1'b0, 3'b101, 8'd8), 0, 16'h0101, 13'd1, 16'h000B, 16'h000A, 16'hAAAA),
                  2, 16'h0202, 13'd1, 16'h4001, 16'h4000, 16'hBBBB);
    tbl[13] = req(mk(1'b0, 3'b010, 8'd4), 1, 16'h5555, 13'd0, 16'h2000, 16'h2000, 16'h5555);
    tbl[14] = req(req(mk(1'b0, 3'b110, 8'd8), 1, 16'h7777, 13'd1, 16'h2001, 16'h2000, 16'h5555),
                  2, 16'h0303, 13'd2, 16'h4002, 16'h4000, 16'hBBBB);
    for (int j = 0; j < 3; j++) exp_rd[j] = '0;

    #2 ADCLRCK = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset rd_data", rd_data, 48'h0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_d", ram_d, 0);
    ADCLRCK = 1'b0;

    for (int i = 0; i < 15; i++) run_frame(tbl[i], $sformatf("row%0d", i));

    // Wrap-around: fill req0 until its pointer reaches the top of the ring.
    do_reset();
    for (int n = 0; n < 8191; n++) begin
      @(negedge clk);
      en = 3'b001;
      wr_data = {32'h0, 16'(n)};
      rd_delay = '0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("wrap fill overrun", overrun, 0);
    run_frame(req(mk(1'b0, 3'b001, 8'd4), 0, 16'hCAFE, 13'd2, 16'h1FFF, 16'h1FFD, 16'h1FFD), "wrap_top");
    run_frame(req(mk(1'b0, 3'b001, 8'd4), 0, 16'hBEEF, 13'd2, 16'h0000, 16'h1FFE, 16'h1FFE), "wrap_zero");

    // Overrun: re-pulse while busy, clear, then set-and-clear in the same cycle.
    do_reset();
    v = req(mk(1'b0, 3'b001, 8'd4), 0, 16'h1111, 13'd0, 16'h0000, 16'h0000, 16'h1111);
    v.glitch = 8'd2;
    v.ovr = 1'b1;
    run_frame(v, "ovr_set");
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr cleared", overrun, 0);
    run_frame(req(mk(1'b0, 3'b001, 8'd4), 0, 16'h2222, 13'd1, 16'h0001, 16'h0000, 16'h1111), "ovr_after");
    v = req(mk(1'b0, 3'b001, 8'd4), 0, 16'h3333, 13'd0, 16'h0002, 16'h0002, 16'h3333);
    v.glitch = 8'd3;
    v.glitch_clr = 1'b1;
    v.ovr = 1'b1;
    run_frame(v, "ovr_setwins");

    // Reset during req1's WAIT aborts the schedule at once.
    do_reset();
    @(negedge clk);
    en = 3'b011;
    wr_data = {16'h0000, 16'h6666, 16'h4444};
    rd_delay = '0;
    frame_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    chk("abort busy before", busy, 1);
    chk("abort rd_data0 before", rd_data[15:0], 16'h4444);
    ADCLRCK = 1'b1;
    #1;
    chk("abort rd_data", rd_data, 48'h0);
    chk("abort rd_valid", rd_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort overrun", overrun, 0);
    chk("abort ram_we", ram_we, 0);
    chk("abort ram_addr", ram_addr, 0);
    chk("abort ram_d", ram_d, 0);
    for (int j = 0; j < 3; j++) exp_rd[j] = '0;
    @(negedge clk);
    @(negedge clk);
    ADCLRCK = 1'b0;
    vseen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_valid[1]) vseen++;
    end
    chk("abort rd_valid1 pulses", vseen, 0);
    $display("abort sequence: rd_valid1 pulses after reset=%0d", vseen);
    run_frame(req(mk(1'b0, 3'b001, 8'd4), 0, 16'h7A7A, 13'd0, 16'h0000, 16'h0000, 16'h7A7A), "abort_wp0");
    run_frame(req(mk(1'b0, 3'b010, 8'd4), 1, 16'h5A5A, 13'd0, 16'h2000, 16'h2000, 16'h5A5A), "abort_wp1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
